// File: rtl/mesi_isc_snoop_dispatch_pkg.sv
// Shared constants for the snoop dispatcher: cbus command codes, broadcast types,
// FSM state encoding and the per-CPU command decode helper.
package mesi_isc_pkg;

    localparam logic [2:0] CBUS_CMD_NOP      = 3'd0;
    localparam logic [2:0] CBUS_CMD_WR_SNOOP = 3'd1;
    localparam logic [2:0] CBUS_CMD_RD_SNOOP = 3'd2;
    localparam logic [2:0] CBUS_CMD_EN_WR    = 3'd3;
    localparam logic [2:0] CBUS_CMD_EN_RD    = 3'd4;

    localparam logic [1:0] BROAD_NOP = 2'd0;
    localparam logic [1:0] BROAD_WR  = 2'd1;
    localparam logic [1:0] BROAD_RD  = 2'd2;
    localparam logic [1:0] BROAD_ILL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        GRANT = 2'd2
    } state_e;

    // Command seen by one CPU given the FSM state, its pending bit and initiator role.
    function automatic logic [2:0] cpu_cmd(input state_e st, input logic pend,
                                           input logic is_init, input logic [1:0] typ);
        logic [2:0] cmd;
        cmd = CBUS_CMD_NOP;
        case (st)
            SNOOP: begin
                if (pend) cmd = (typ == BROAD_WR) ? CBUS_CMD_WR_SNOOP : CBUS_CMD_RD_SNOOP;
                else      cmd = CBUS_CMD_NOP;
            end
            GRANT: begin
                if (is_init) cmd = (typ == BROAD_WR) ? CBUS_CMD_EN_WR : CBUS_CMD_EN_RD;
                else         cmd = CBUS_CMD_NOP;
            end
            default: cmd = CBUS_CMD_NOP;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/mesi_isc_snoop_dispatch_if.sv
// Broad-FIFO head/pop and cbus command/ack signals between the dispatcher (master)
// and the FIFO plus CPU-side logic (slave).
interface mesi_isc_snoop_dispatch_if #(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7
);
    logic                          broad_fifo_status_empty_i;
    logic [ADDR_WIDTH-1:0]         broad_addr_i;
    logic [BROAD_TYPE_WIDTH-1:0]   broad_type_i;
    logic [1:0]                    broad_cpu_id_i;
    logic [BROAD_ID_WIDTH-1:0]     broad_id_i;
    logic                          broad_fifo_rd_o;
    logic [ADDR_WIDTH-1:0]         cbus_addr_o;
    logic [4*CBUS_CMD_WIDTH-1:0]   cbus_cmd_array_o;
    logic [3:0]                    cbus_ack_array_i;
    logic [BROAD_ID_WIDTH-1:0]     active_id_o;

    modport master (
        input  broad_fifo_status_empty_i, broad_addr_i, broad_type_i, broad_cpu_id_i,
               broad_id_i, cbus_ack_array_i,
        output broad_fifo_rd_o, cbus_addr_o, cbus_cmd_array_o, active_id_o
    );

    modport slave (
        output broad_fifo_status_empty_i, broad_addr_i, broad_type_i, broad_cpu_id_i,
               broad_id_i, cbus_ack_array_i,
        input  broad_fifo_rd_o, cbus_addr_o, cbus_cmd_array_o, active_id_o
    );
endinterface

// File: rtl/mesi_isc_snoop_timer.sv
// Ack watchdog: counts waiting cycles without an accepted ack and flags expiry
// so the dispatcher can force its next state. Used under MESI_ISC_SNOOP_TIMEOUT_EN.
module mesi_isc_snoop_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting_i,
    input  logic clear_i,
    output logic expired_o
);
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Expiry in the last allowed waiting cycle, unless an ack makes progress in it.
    assign expired_o = waiting_i && !clear_i && (cnt_q >= CNT_WIDTH'(TIMEOUT_CYCLES - 1));

    // Next count: restart on idle, progress or forced transition.
    always_comb begin
        cnt_d = cnt_q;
        if (!waiting_i || clear_i || expired_o) cnt_d = '0;
        else                                    cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mesi_isc_snoop_dispatch.sv
// Pops broadcast requests, snoops the three non-initiating CPUs, then grants the initiator.
// Optional ack watchdog enabled by defining MESI_ISC_SNOOP_TIMEOUT_EN.
module mesi_isc_snoop_dispatch
    import mesi_isc_pkg::*;
#(
    parameter int CBUS_CMD_WIDTH   = 3,
    parameter int ADDR_WIDTH       = 32,
    parameter int BROAD_TYPE_WIDTH = 2,
    parameter int BROAD_ID_WIDTH   = 7,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    mesi_isc_snoop_dispatch_if.master bus,
    output logic                      busy_o,
    output logic                      err_o
);
    state_e                      state_q, state_d;
    logic [3:0]                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]       addr_q;
    logic [BROAD_TYPE_WIDTH-1:0] type_q, type_nxt_s;
    logic [1:0]                  cpu_q, cpu_nxt_s;
    logic [BROAD_ID_WIDTH-1:0]   id_q;
    logic                        err_q, err_d;
    logic [4*CBUS_CMD_WIDTH-1:0] cmd_q, cmd_d;
    logic                        pop_s;
    logic                        expired_s;

    assign pop_s      = !rst && (state_q == IDLE) && !bus.broad_fifo_status_empty_i;
    assign type_nxt_s = pop_s ? bus.broad_type_i : type_q;
    assign cpu_nxt_s  = pop_s ? bus.broad_cpu_id_i : cpu_q;

`ifdef MESI_ISC_SNOOP_TIMEOUT_EN
    logic waiting_s;
    logic ack_accept_s;

    assign waiting_s    = (state_q != IDLE);
    assign ack_accept_s = ((state_q == SNOOP) && (|(bus.cbus_ack_array_i & pend_q)))
                       || ((state_q == GRANT) && bus.cbus_ack_array_i[cpu_q]);

    mesi_isc_snoop_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .waiting_i (waiting_s),
        .clear_i   (ack_accept_s),
        .expired_o (expired_s)
    );
`else
    assign expired_s = 1'b0;
`endif

    // Next state, pending mask, sticky error and the registered per-CPU commands.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = err_q;
        cmd_d   = '0;
        case (state_q)
            IDLE: begin
                if (pop_s) begin
                    if ((bus.broad_type_i == BROAD_WR) || (bus.broad_type_i == BROAD_RD)) begin
                        state_d = SNOOP;
                        pend_d  = 4'b1111 & ~(4'b0001 << bus.broad_cpu_id_i);
                    end else if (bus.broad_type_i == BROAD_ILL) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SNOOP: begin
                pend_d = pend_q & ~bus.cbus_ack_array_i;
                if (pend_d == 4'b0000) begin
                    state_d = GRANT;
                end else if (expired_s) begin
                    state_d = GRANT;
                    pend_d  = 4'b0000;
                    err_d   = 1'b1;
                end else begin
                    state_d = SNOOP;
                end
            end
            GRANT: begin
                if (bus.cbus_ack_array_i[cpu_q]) begin
                    state_d = IDLE;
                end else if (expired_s) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = 4'b0000;
            end
        endcase
        for (int k = 0; k < 4; k++) begin
            cmd_d[k*CBUS_CMD_WIDTH +: CBUS_CMD_WIDTH] =
                CBUS_CMD_WIDTH'(cpu_cmd(state_d, pend_d[k], (cpu_nxt_s == 2'(k)), type_nxt_s));
        end
    end

    // State, mask, command and transaction registers; head entry latched on pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= 4'b0000;
            err_q   <= 1'b0;
            cmd_q   <= '0;
            addr_q  <= '0;
            type_q  <= '0;
            cpu_q   <= 2'b00;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            if (pop_s) begin
                addr_q <= bus.broad_addr_i;
                type_q <= bus.broad_type_i;
                cpu_q  <= bus.broad_cpu_id_i;
                id_q   <= bus.broad_id_i;
            end
        end
    end

    assign bus.broad_fifo_rd_o  = pop_s;
    assign bus.cbus_addr_o      = addr_q;
    assign bus.cbus_cmd_array_o = cmd_q;
    assign bus.active_id_o      = id_q;
    assign busy_o               = (state_q != IDLE);
    assign err_o                = err_q;
endmodule

// File: tb/tb_mesi_isc_snoop_dispatch.sv
// Self-checking bench for mesi_isc_snoop_dispatch: directed scenarios plus random
// traffic against a transaction-level reference model and a queue-based broad FIFO.
module tb_mesi_isc_snoop_dispatch;
    import mesi_isc_pkg::*;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err;
    logic [3:0] ack;

    mesi_isc_snoop_dispatch_if bus ();

    mesi_isc_snoop_dispatch #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy_o (busy),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  typ;
        logic [1:0]  cpu;
        logic [6:0]  id;
    } entry_t;

    entry_t fifo[$];
    int tests = 0;
    int fails = 0;

    // Reference model: one transaction, the set of CPUs still owing an ack, grant flag.
    bit          m_busy, m_grant, m_err;
    int          m_type, m_cpu, m_stall;
    bit [3:0]    m_wait;
    logic [31:0] m_addr;
    logic [6:0]  m_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Snoop code equals the broadcast type; grant code is type + 2.
    function automatic logic [11:0] exp_cmds();
        logic [11:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) begin
            int c;
            c = 0;
            if (m_busy && !m_grant && m_wait[k]) c = m_type;
            if (m_busy && m_grant && (k == m_cpu)) c = m_type + 2;
            v[k*3 +: 3] = 3'(c);
        end
        return v;
    endfunction

    task automatic push(input logic [31:0] a, input logic [1:0] t, input logic [1:0] c, input logic [6:0] i);
        entry_t e;
        e.addr = a; e.typ = t; e.cpu = c; e.id = i;
        fifo.push_back(e);
    endtask

    task automatic stall_step();
`ifdef MESI_ISC_SNOOP_TIMEOUT_EN
        m_stall++;
        if (m_stall == TO) begin
            m_err   = 1'b1;
            m_stall = 0;
            if (!m_grant) begin
                m_grant = 1'b1;
                m_wait  = 4'b0000;
            end else begin
                m_busy  = 1'b0;
                m_grant = 1'b0;
            end
        end
`endif
    endtask

    task automatic model_advance(input logic [3:0] a, input logic r);
        if (r) begin
            m_busy = 0; m_grant = 0; m_err = 0; m_wait = 0; m_stall = 0;
            m_addr = '0; m_id = '0; m_type = 0; m_cpu = 0;
        end else if (!m_busy) begin
            if (fifo.size() != 0) begin
                m_addr = fifo[0].addr;
                m_id   = fifo[0].id;
                if (fifo[0].typ == 2'd1 || fifo[0].typ == 2'd2) begin
                    m_busy  = 1'b1;
                    m_grant = 1'b0;
                    m_type  = int'(fifo[0].typ);
                    m_cpu   = int'(fifo[0].cpu);
                    m_stall = 0;
                    for (int k = 0; k < 4; k++) m_wait[k] = (k != m_cpu);
                end else if (fifo[0].typ == 2'd3) begin
                    m_err = 1'b1;
                end
            end
        end else if (!m_grant) begin
            bit [3:0] accepted;
            accepted = m_wait & a;
            m_wait   = m_wait & ~a;
            if (m_wait == 4'b0000) begin
                m_grant = 1'b1;
                m_stall = 0;
            end else if (accepted != 4'b0000) begin
                m_stall = 0;
            end else begin
                stall_step();
            end
        end else begin
            if (a[m_cpu]) begin
                m_busy  = 1'b0;
                m_grant = 1'b0;
                m_stall = 0;
            end else begin
                stall_step();
            end
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle, advance model, let the FIFO react.
    task automatic cycle(input logic [3:0] a, input logic r);
        logic rd_seen;
        logic exp_rd;
        ack = a;
        rst = r;
        bus.cbus_ack_array_i          = a;
        bus.broad_fifo_status_empty_i = (fifo.size() == 0);
        if (fifo.size() != 0) begin
            bus.broad_addr_i   = fifo[0].addr;
            bus.broad_type_i   = fifo[0].typ;
            bus.broad_cpu_id_i = fifo[0].cpu;
            bus.broad_id_i     = fifo[0].id;
        end else begin
            bus.broad_addr_i   = '0;
            bus.broad_type_i   = '0;
            bus.broad_cpu_id_i = '0;
            bus.broad_id_i     = '0;
        end
        #1;
        exp_rd = !r && !m_busy && (fifo.size() != 0);
        chk("rd",   64'(bus.broad_fifo_rd_o),  64'(exp_rd));
        chk("cmd",  64'(bus.cbus_cmd_array_o), 64'(exp_cmds()));
        chk("addr", 64'(bus.cbus_addr_o),      64'(m_addr));
        chk("id",   64'(bus.active_id_o),      64'(m_id));
        chk("busy", 64'(busy),                 64'(m_busy));
        chk("err",  64'(err),                  64'(m_err));
        rd_seen = bus.broad_fifo_rd_o;
        model_advance(a, r);
        @(posedge clk);
        if (rd_seen === 1'b1 && fifo.size() != 0) void'(fifo.pop_front());
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ack = 4'b0000;
        bus.cbus_ack_array_i          = 4'b0000;
        bus.broad_fifo_status_empty_i = 1'b1;
        bus.broad_addr_i   = '0;
        bus.broad_type_i   = '0;
        bus.broad_cpu_id_i = '0;
        bus.broad_id_i     = '0;
        model_advance(4'b0000, 1'b1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        // WR_BROAD from CPU2, all snoop acks together
        push(32'h0000_1000, 2'd1, 2'd2, 7'd5);
        cycle(4'b0000, 1'b0);
        cycle(4'b1011, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);

        // RD_BROAD from CPU0, acks staggered CPU3, CPU1, CPU2
        push($urandom, 2'd2, 2'd0, 7'($urandom));
        cycle(4'b0000, 1'b0);
        cycle(4'b1000, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0001, 1'b0);
        cycle(4'b0000, 1'b0);

        // Three back-to-back entries, then an empty FIFO
        for (int i = 0; i < 3; i++) push($urandom, 2'($urandom_range(1, 2)), 2'($urandom_range(0, 3)), 7'($urandom));
        repeat (12) cycle(4'b1111, 1'b0);
        repeat (3) cycle(4'b0000, 1'b0);

        // Spurious acks: initiator during SNOOP, others during GRANT
        push($urandom, 2'd1, 2'd1, 7'($urandom));
        cycle(4'b0000, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle(4'b1101, 1'b0);
        cycle(4'b1101, 1'b0);
        cycle(4'b1101, 1'b0);
        cycle(4'b0010, 1'b0);
        cycle(4'b0000, 1'b0);

        // Illegal type, then reset in the middle of a snoop
        push($urandom, 2'd3, 2'($urandom_range(0, 3)), 7'($urandom));
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        push($urandom, 2'd2, 2'd3, 7'($urandom));
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        // Random traffic with occasional resets
        repeat (400) begin
            if (($urandom % 3 == 0) && (fifo.size() < 4))
                push($urandom, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 7'($urandom));
            cycle(4'($urandom), ($urandom % 150) == 0);
        end
        cycle(4'b0000, 1'b1);
        fifo.delete();
        cycle(4'b0000, 1'b0);

        // CPU1 never acks: watchdog forces grant when enabled, otherwise snoop persists
        push($urandom, 2'd1, 2'd0, 7'($urandom));
        cycle(4'b0000, 1'b0);
        cycle(4'b1100, 1'b0);
        repeat (20) cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
